// File: rtl/wm8731_pkg.sv
// Shared constants and sample types for the WM8731 audio interface blocks.
// Frame geometry is one 32-slot I2S frame: left word first, then right word.
package wm8731_pkg;

    localparam int CH_WIDTH   = 16;
    localparam int FRAME_BITS = 32;
    localparam int SLOT_W     = 5;

    localparam logic [SLOT_W-1:0] LOAD_SLOT        = 5'd1;
    localparam logic [SLOT_W-1:0] RIGHT_FIRST_SLOT = 5'd16;
    localparam logic [SLOT_W-1:0] IDLE_SLOT        = 5'd31;

    typedef struct packed {
        logic [CH_WIDTH-1:0] left;
        logic [CH_WIDTH-1:0] right;
    } stereo_sample_t;

    // DACLRC is high for the second half of the frame.
    function automatic logic is_right_slot(input logic [SLOT_W-1:0] slot);
        return slot >= RIGHT_FIRST_SLOT;
    endfunction

endpackage

// File: rtl/wm8731_bclk_gen.sv
// I2S bit-clock divider shared by the DAC transmit and ADC receive paths.
// fall_evt_o is high in the cycle whose closing clk edge drops bclk_o.
module wm8731_bclk_gen #(
    parameter int BCLK_HALF_DIV = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic bclk_o,
    output logic fall_evt_o
);

    localparam int CNT_W = (BCLK_HALF_DIV > 2) ? $clog2(BCLK_HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BCLK_HALF_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bclk_q, bclk_d;
    logic             wrap;

    always_comb begin
        wrap   = en_i & (cnt_q == CNT_MAX);
        cnt_d  = cnt_q;
        bclk_d = bclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            bclk_d = 1'b0;
        end else if (wrap) begin
            cnt_d  = '0;
            bclk_d = ~bclk_q;
        end else begin
            cnt_d  = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk_o     = bclk_q;
    assign fall_evt_o = wrap & bclk_q;

endmodule

// File: rtl/wm8731_i2s_tx.sv
// I2S master transmitter for the WM8731 DAC: one-word holding register,
// 32-slot frame counter and MSB-first shifter, all timed off BCLK falls.
module wm8731_i2s_tx
    import wm8731_pkg::*;
#(
    parameter int BCLK_HALF_DIV = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [FRAME_BITS-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic                  bclk_o,
    output logic                  daclrc_o,
    output logic                  dacdat_o,
    output logic                  frame_start_o,
    output logic                  underrun_o
);

    logic fall_evt;

    wm8731_bclk_gen #(
        .BCLK_HALF_DIV (BCLK_HALF_DIV)
    ) u_bclk_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .bclk_o     (bclk_o),
        .fall_evt_o (fall_evt)
    );

    stereo_sample_t        hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  daclrc_q, daclrc_d;
    logic                  dacdat_q, dacdat_d;
    logic                  frame_start_q, frame_start_d;
    logic                  underrun_q, underrun_d;

    logic [SLOT_W-1:0]     slot_next;
    logic                  load;
    logic                  accept;

    assign s_ready_o = ~hold_full_q & ~rst_i;

    always_comb begin
        slot_next     = slot_q + 5'd1;
        load          = fall_evt & (slot_next == LOAD_SLOT);
        accept        = s_valid_i & s_ready_o;

        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        slot_d        = slot_q;
        shift_d       = shift_q;
        daclrc_d      = daclrc_q;
        dacdat_d      = dacdat_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (!en_i) begin
            slot_d   = IDLE_SLOT;
            shift_d  = '0;
            daclrc_d = 1'b0;
            dacdat_d = 1'b0;
        end else if (fall_evt) begin
            slot_d   = slot_next;
            daclrc_d = is_right_slot(slot_next);
            // The MSB goes straight to the pin, so the shifter holds only the rest.
            if (load) begin
                if (hold_full_q) begin
                    shift_d       = {hold_q[FRAME_BITS-2:0], 1'b0};
                    dacdat_d      = hold_q[FRAME_BITS-1];
                    frame_start_d = 1'b1;
                end else begin
                    shift_d       = '0;
                    dacdat_d      = 1'b0;
                    underrun_d    = 1'b1;
                end
            end else begin
                dacdat_d = shift_q[FRAME_BITS-1];
                shift_d  = {shift_q[FRAME_BITS-2:0], 1'b0};
            end
        end

        // Accept only happens when empty, load only empties when full.
        if (accept) begin
            hold_d      = stereo_sample_t'(s_data_i);
            hold_full_d = 1'b1;
        end else if (load && hold_full_q) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            slot_q        <= IDLE_SLOT;
            shift_q       <= '0;
            daclrc_q      <= 1'b0;
            dacdat_q      <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            slot_q        <= slot_d;
            shift_q       <= shift_d;
            daclrc_q      <= daclrc_d;
            dacdat_q      <= dacdat_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign daclrc_o      = daclrc_q;
    assign dacdat_o      = dacdat_q;
    assign frame_start_o = frame_start_q;
    assign underrun_o    = underrun_q;

endmodule
